// File: rtl/multicycle_sequencer_if.sv
// Handshake bundle between the multi-cycle sequencer and its instruction
// memory, data memory and datapath.
interface multicycle_sequencer_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
);
  logic               start;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] ir;
  logic [3:0]         alu_op;
  logic               reg_we;
  logic               dmem_req;
  logic               dmem_ready;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   retired;

  modport master (
    input  start, imem_ready, imem_rdata, dmem_ready,
    output imem_req, imem_addr, ir, alu_op, reg_we, dmem_req, busy, done, retired
  );

  modport slave (
    output start, imem_ready, imem_rdata, dmem_ready,
    input  imem_req, imem_addr, ir, alu_op, reg_we, dmem_req, busy, done, retired
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 2-bit-opcode core.
// Owns pc, the instruction register, the halt condition and the retire count.
module multicycle_sequencer #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_sequencer_if.master bus
);

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, MEM} state_t;

  state_t             state, state_nxt;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  logic [CNT_W-1:0]   retired;
  logic [1:0]         opcode;
  logic               is_halt;
  logic               clear_ctx;
  logic               load_ir;
  logic               retire;

  function automatic logic [3:0] alu_decode(input logic [1:0] op);
    case (op)
      2'b00:   return ALU_ADD;
      2'b01:   return ALU_SUB;
      2'b10:   return ALU_SLT;
      default: return ALU_ADD;  // store computes its address with an add
    endcase
  endfunction

  assign opcode  = ir[INSTR_W-1 -: 2];
  assign is_halt = &ir;

  assign bus.imem_addr = pc;
  assign bus.ir        = ir;
  assign bus.retired   = retired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= '0;
      ir      <= '0;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (clear_ctx) begin
        pc      <= '0;
        retired <= '0;
      end else if (retire) begin
        pc      <= pc + PC_W'(1);
        retired <= retired + CNT_W'(1);
      end
      if (load_ir) begin
        ir <= bus.imem_rdata;
      end
    end
  end

  // Outputs depend on the registered state and ir only; the readies steer
  // just the next state and the register enables.
  always_comb begin
    state_nxt    = state;
    clear_ctx    = 1'b0;
    load_ir      = 1'b0;
    retire       = 1'b0;
    bus.imem_req = 1'b0;
    bus.reg_we   = 1'b0;
    bus.dmem_req = 1'b0;
    bus.done     = 1'b0;
    bus.busy     = 1'b1;
    bus.alu_op   = ALU_NOP;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          clear_ctx = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ready) begin
          load_ir   = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        if (is_halt) begin
          bus.done  = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        bus.alu_op = alu_decode(opcode);
        state_nxt  = (opcode == 2'b11) ? MEM : WB;
      end
      WB: begin
        bus.alu_op = alu_decode(opcode);
        bus.reg_we = 1'b1;
        retire     = 1'b1;
        state_nxt  = FETCH;
      end
      MEM: begin
        bus.alu_op   = ALU_ADD;
        bus.dmem_req = 1'b1;
        if (bus.dmem_ready) begin
          retire    = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: a program-level reference model
// queues the expected retire/halt events and a monitor checks them.
module tb_multicycle_sequencer;
  localparam int PC_W    = 2;
  localparam int INSTR_W = 16;
  localparam int CNT_W   = 3;
  localparam logic [INSTR_W-1:0] HALT = '1;

  typedef struct {
    int                 kind;   // 0 = register writeback, 1 = store accept, 2 = halt
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [3:0]         alu;
    logic [CNT_W-1:0]   ret;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  multicycle_sequencer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();
  multicycle_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  logic [INSTR_W-1:0] mem [4];
  int iw = 0, dw = 0;
  ev_t exp_q [$];

  // run statistics
  int done_cyc, dreq_cnt, alu_nz, alu_bad, ir_bad;
  int we_cyc [$];
  int req_runs [$];
  logic [PC_W-1:0]  first_addr, done_addr;
  logic [CNT_W-1:0] first_ret, done_ret;
  logic             first_req;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] ref_alu(input logic [INSTR_W-1:0] w);
    case (w[INSTR_W-1 -: 2])
      2'd1:    return 4'b0110;
      2'd2:    return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  // Reference model: walk the program and queue the events it must produce,
  // with the cycle of the halt pulse and the number of cycles with a live alu_op.
  task automatic predict(input int max_ev, output int exp_cyc, output int exp_alu,
                         output int exp_ret, output int exp_pc);
    int pc, ret, cyc, alucyc;
    ev_t ev;
    pc = 0; ret = 0; cyc = 0; alucyc = 0; exp_cyc = -1;
    for (int n = 0; n < max_ev; n++) begin
      ev.pc    = PC_W'(pc);
      ev.instr = mem[pc];
      ev.ret   = CNT_W'(ret);
      ev.alu   = ref_alu(mem[pc]);
      cyc += iw + 2;
      if (mem[pc] == HALT) begin
        ev.kind = 2;
        exp_q.push_back(ev);
        exp_cyc = cyc;
        break;
      end
      if (mem[pc][INSTR_W-1 -: 2] == 2'b11) begin
        ev.kind = 1; cyc += 2 + dw; alucyc += 2 + dw;
      end else begin
        ev.kind = 0; cyc += 2; alucyc += 2;
      end
      exp_q.push_back(ev);
      pc  = (pc + 1) % (1 << PC_W);
      ret = (ret + 1) % (1 << CNT_W);
    end
    exp_alu = alucyc;
    exp_ret = ret;
    exp_pc  = pc;
  endtask

  // Memory responder with a fixed number of wait cycles per request.
  initial begin : responder
    int icnt, dcnt;
    icnt = 0; dcnt = 0;
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.imem_req === 1'b1) begin
        if (icnt >= iw) begin
          bus.imem_ready = 1'b1; bus.imem_rdata = mem[bus.imem_addr]; icnt = 0;
        end else begin
          bus.imem_ready = 1'b0; bus.imem_rdata = INSTR_W'($urandom); icnt++;
        end
      end else begin
        bus.imem_ready = 1'b0; icnt = 0;
      end
      if (bus.dmem_req === 1'b1) begin
        if (dcnt >= dw) begin bus.dmem_ready = 1'b1; dcnt = 0; end
        else begin bus.dmem_ready = 1'b0; dcnt++; end
      end else begin
        bus.dmem_ready = 1'b0; dcnt = 0;
      end
    end
  end

  // Monitor: pop and compare on every writeback, store accept or halt.
  initial begin : monitor
    ev_t e;
    int kind;
    forever begin
      @(negedge clk); #1;
      if (rst_n && (bus.reg_we || (bus.dmem_req && bus.dmem_ready) || bus.done)) begin
        kind = bus.done ? 2 : (bus.reg_we ? 0 : 1);
        if (bus.reg_we && bus.dmem_req) check("we_and_dmem_req", 1, 0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: kind %0d with empty queue", kind);
        end else begin
          e = exp_q.pop_front();
          check("ev_kind", kind, e.kind);
          check("ev_pc", bus.imem_addr, e.pc);
          check("ev_ir", bus.ir, e.instr);
          check("ev_retired", bus.retired, e.ret);
          if (kind != 2) check("ev_alu_op", bus.alu_op, e.alu);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic do_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  // Observe one run from its first FETCH cycle (k = 1) until done.
  task automatic run(input int maxc, input bit abuse);
    logic prev_ready;
    logic [INSTR_W-1:0] prev_ir;
    int run_len;
    done_cyc = -1; dreq_cnt = 0; alu_nz = 0; alu_bad = 0; ir_bad = 0; run_len = 0;
    we_cyc.delete(); req_runs.delete();
    prev_ready = 1'b0; prev_ir = '0;
    for (int k = 1; k <= maxc; k++) begin
      #1;
      if (k == 1) begin
        first_addr = bus.imem_addr; first_ret = bus.retired; first_req = bus.imem_req;
      end else if (bus.ir !== prev_ir && !prev_ready) begin
        ir_bad++;
      end
      prev_ir = bus.ir; prev_ready = bus.imem_ready;
      if (bus.imem_req) run_len++;
      else if (run_len > 0) begin req_runs.push_back(run_len); run_len = 0; end
      if (bus.reg_we) we_cyc.push_back(k);
      if (bus.dmem_req) dreq_cnt++;
      if (bus.alu_op != 4'b0000) begin
        alu_nz++;
        if (bus.alu_op !== ref_alu(bus.ir)) alu_bad++;
      end
      if (bus.done) begin
        done_cyc = k; done_addr = bus.imem_addr; done_ret = bus.retired;
        break;
      end
      if (abuse) bus.start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic finish_run(input int exp_cyc, input int exp_alu, input int exp_ret, input int exp_pc);
    check("first_fetch_addr", first_addr, 0);
    check("first_fetch_retired", first_ret, 0);
    check("first_fetch_req", first_req, 1);
    check("done_cycle", done_cyc, exp_cyc);
    check("alu_active_cycles", alu_nz, exp_alu);
    check("alu_op_value_errs", alu_bad, 0);
    check("ir_change_errs", ir_bad, 0);
    check("halt_retired", done_ret, exp_ret);
    check("halt_pc", done_addr, exp_pc);
    @(negedge clk); #2;
    check("busy_after_done", bus.busy, 0);
    check("done_one_cycle", bus.done, 0);
    check("queue_drained", exp_q.size(), 0);
    if (done_cyc < 0) do_reset();
  endtask

  initial begin : stimulus
    int ec, ea, er, ep, nf, L;
    logic prev_req;
    logic [INSTR_W-1:0] w;
    bit ab;
    bus.start = 1'b0;
    mem[0] = '0; mem[1] = '0; mem[2] = '0; mem[3] = '0;

    // reset values
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_imem_req", bus.imem_req, 0);
    check("rst_reg_we", bus.reg_we, 0);
    check("rst_dmem_req", bus.dmem_req, 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_alu_op", bus.alu_op, 0);
    check("rst_ir", bus.ir, 0);
    check("rst_retired", bus.retired, 0);
    check("rst_pc", bus.imem_addr, 0);
    @(negedge clk); rst_n = 1'b1;

    // add, sub, cmp, HALT with no wait states
    mem[0] = 16'h0123; mem[1] = 16'h4567; mem[2] = 16'h89AB; mem[3] = HALT;
    iw = 0; dw = 0;
    predict(8, ec, ea, er, ep);
    do_start(); run(60, 1'b0);
    check("alu_seq_we_count", we_cyc.size(), 3);
    if (we_cyc.size() == 3) begin
      check("alu_seq_we0", we_cyc[0], 4);
      check("alu_seq_we1", we_cyc[1], 8);
      check("alu_seq_we2", we_cyc[2], 12);
    end
    finish_run(ec, ea, er, ep);
    check("alu_seq_done_at_14", ec, 14);

    // same program with start toggling while busy, restarted from a halted state
    predict(8, ec, ea, er, ep);
    do_start(); run(60, 1'b1);
    finish_run(ec, ea, er, ep);

    // three wait states on every fetch
    mem[0] = 16'h1111; mem[1] = 16'h8222; mem[2] = 16'h4333; mem[3] = HALT;
    iw = 3; dw = 0;
    predict(8, ec, ea, er, ep);
    do_start(); run(80, 1'b0);
    check("wait_we_count", we_cyc.size(), 3);
    if (we_cyc.size() == 3) check("wait_we2", we_cyc[2], 21);
    check("wait_req_runs", req_runs.size(), 4);
    foreach (req_runs[i]) check("wait_req_run_len", req_runs[i], 4);
    finish_run(ec, ea, er, ep);

    // store with two data-memory wait states
    mem[0] = 16'hC0DE; mem[1] = HALT;
    iw = 0; dw = 2;
    predict(8, ec, ea, er, ep);
    do_start(); run(60, 1'b0);
    check("store_dmem_req_cycles", dreq_cnt, 3);
    check("store_no_reg_we", we_cyc.size(), 0);
    finish_run(ec, ea, er, ep);

    // pc wrap with a 4-word program, then reset in the middle of a store
    mem[0] = 16'h0001; mem[1] = 16'h4002; mem[2] = 16'h8003; mem[3] = 16'hC004;
    iw = 0; dw = 0;
    predict(12, ec, ea, er, ep);
    do_start();
    nf = 0; prev_req = 1'b0;
    for (int k = 0; k < 100 && nf < 5; k++) begin
      #1;
      if (bus.imem_req && !prev_req) begin
        nf++;
        if (nf == 5) begin
          check("wrap_fetch_addr", bus.imem_addr, 0);
          check("wrap_retired", bus.retired, 4);
        end
      end
      prev_req = bus.imem_req;
      if (nf == 5) dw = 6;
      @(negedge clk);
    end
    check("wrap_fetch_count", nf, 5);
    for (int k = 0; k < 100 && !bus.dmem_req; k++) @(negedge clk);
    #1 check("abort_dmem_req_seen", bus.dmem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_dmem_req", bus.dmem_req, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_retired", bus.retired, 0);
    check("abort_pc", bus.imem_addr, 0);
    check("abort_alu_op", bus.alu_op, 0);
    check("abort_ir", bus.ir, 0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    dw = 0;

    // randomized programs, wait states and start toggling
    for (int it = 0; it < 12; it++) begin
      L = int'($urandom_range(1, 4));
      for (int i = 0; i < 4; i++) begin
        w = INSTR_W'($urandom);
        if (w == HALT) w = 16'h0000;
        mem[i] = (i == L - 1) ? HALT : w;
      end
      iw = int'($urandom_range(0, 3));
      dw = int'($urandom_range(0, 3));
      ab = 1'($urandom_range(0, 1));
      predict(8, ec, ea, er, ep);
      do_start(); run(200, ab);
      finish_run(ec, ea, er, ep);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
